// File: rtl/dso_reg_ctrl_if.sv
// Byte-stream link between the serial PHY and the register responder.
// The master is the PHY side; the slave is the register responder.
interface dso_reg_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        output tx_ready,
        input  tx_data,
        input  tx_valid
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  tx_ready,
        output tx_data,
        output tx_valid
    );
endinterface

// File: rtl/dso_reg_ctrl.sv
// Register responder: parses write/read byte frames, holds the DSO/DDS control
// registers and returns measurement read-backs over the byte stream.
module dso_reg_ctrl #(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    dso_reg_ctrl_if.slave       bus,
    input  logic [19:0]         ad_freq,
    input  logic [7:0]          ad_vpp,
    input  logic [7:0]          ad_max,
    input  logic [7:0]          ad_min,
    output logic [7:0]          trig_level,
    output logic [9:0]          deci_rate,
    output logic                wave_run,
    output logic                trig_edge,
    output logic                fft_en,
    output logic                fir_en,
    output logic [4:0]          v_scale,
    output logic [11:0]         trig_line,
    output logic [3:0]          wave_select
);
    localparam logic [7:0] HDR_WRITE = 8'h57;
    localparam logic [7:0] HDR_READ  = 8'h52;
    localparam logic [7:0] ACK       = 8'h06;
    localparam logic [7:0] NAK       = 8'h15;
    localparam int         CNT_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {IDLE, ADDR, DHI, DLO, EXEC, TX0, TX1, TX2} state_t;

    state_t           state_reg;
    logic             is_write_reg;
    logic [7:0]       addr_reg;
    logic [11:0]      wdata_reg;
    logic [15:0]      rdata_reg;
    logic [3:0]       shadow_reg;
    logic [CNT_W-1:0] gap_reg;
    logic [7:0]       tx_data_reg;
    logic             tx_valid_reg;

    logic [7:0]  trig_level_reg;
    logic [9:0]  deci_rate_reg;
    logic        wave_run_reg;
    logic        trig_edge_reg;
    logic        fft_en_reg;
    logic        fir_en_reg;
    logic [4:0]  v_scale_reg;
    logic [11:0] trig_line_reg;
    logic [3:0]  wave_select_reg;

    logic        addr_rw;
    logic        tx_fire;
    logic [15:0] rd_mux;

    assign addr_rw = (addr_reg < 8'h06);
    assign tx_fire = tx_valid_reg & bus.tx_ready;

    always_comb begin
        rd_mux = 16'h0000;
        case (addr_reg)
            8'h00:   rd_mux = {8'h00, trig_level_reg};
            8'h01:   rd_mux = {6'h00, deci_rate_reg};
            8'h02:   rd_mux = {12'h000, fir_en_reg, fft_en_reg, trig_edge_reg, wave_run_reg};
            8'h03:   rd_mux = {11'h000, v_scale_reg};
            8'h04:   rd_mux = {4'h0, trig_line_reg};
            8'h05:   rd_mux = {12'h000, wave_select_reg};
            8'h10:   rd_mux = ad_freq[15:0];
            8'h11:   rd_mux = {12'h000, shadow_reg};
            8'h12:   rd_mux = {8'h00, ad_vpp};
            8'h13:   rd_mux = {8'h00, ad_max};
            8'h14:   rd_mux = {8'h00, ad_min};
            default: rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg       <= IDLE;
            is_write_reg    <= 1'b0;
            addr_reg        <= 8'h00;
            wdata_reg       <= 12'h000;
            rdata_reg       <= 16'h0000;
            shadow_reg      <= 4'h0;
            gap_reg         <= '0;
            tx_data_reg     <= 8'h00;
            tx_valid_reg    <= 1'b0;
            trig_level_reg  <= 8'h7F;
            deci_rate_reg   <= 10'd1;
            wave_run_reg    <= 1'b1;
            trig_edge_reg   <= 1'b1;
            fft_en_reg      <= 1'b0;
            fir_en_reg      <= 1'b0;
            v_scale_reg     <= 5'h12;
            trig_line_reg   <= 12'd512;
            wave_select_reg <= 4'h0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.rx_valid && (bus.rx_data == HDR_WRITE || bus.rx_data == HDR_READ)) begin
                        is_write_reg <= (bus.rx_data == HDR_WRITE);
                        gap_reg      <= '0;
                        state_reg    <= ADDR;
                    end
                end
                ADDR, DHI, DLO: begin
                    // An arriving byte wins over a timeout expiring in the same cycle.
                    if (bus.rx_valid) begin
                        gap_reg <= '0;
                        case (state_reg)
                            ADDR: begin
                                addr_reg  <= bus.rx_data;
                                state_reg <= is_write_reg ? DHI : EXEC;
                            end
                            DHI: begin
                                wdata_reg[11:8] <= bus.rx_data[3:0];
                                state_reg       <= DLO;
                            end
                            default: begin
                                wdata_reg[7:0] <= bus.rx_data;
                                state_reg      <= EXEC;
                            end
                        endcase
                    end else if (gap_reg == GAP_LAST) begin
                        state_reg <= IDLE;
                    end else begin
                        gap_reg <= gap_reg + CNT_W'(1);
                    end
                end
                EXEC: begin
                    if (is_write_reg) begin
                        if (addr_rw) begin
                            case (addr_reg[2:0])
                                3'd0: trig_level_reg <= wdata_reg[7:0];
                                3'd1: deci_rate_reg  <= wdata_reg[9:0];
                                3'd2: begin
                                    wave_run_reg  <= wdata_reg[0];
                                    trig_edge_reg <= wdata_reg[1];
                                    fft_en_reg    <= wdata_reg[2];
                                    fir_en_reg    <= wdata_reg[3];
                                end
                                3'd3: v_scale_reg     <= wdata_reg[4:0];
                                3'd4: trig_line_reg   <= wdata_reg[11:0];
                                3'd5: wave_select_reg <= wdata_reg[3:0];
                                default: ;
                            endcase
                        end
                        tx_data_reg <= addr_rw ? ACK : NAK;
                    end else begin
                        // Snapshot all read data now so later ad_* changes cannot tear the response.
                        rdata_reg   <= rd_mux;
                        tx_data_reg <= addr_reg;
                        if (addr_reg == 8'h10)
                            shadow_reg <= ad_freq[19:16];
                    end
                    tx_valid_reg <= 1'b1;
                    state_reg    <= TX0;
                end
                TX0: begin
                    if (tx_fire) begin
                        if (is_write_reg) begin
                            tx_valid_reg <= 1'b0;
                            state_reg    <= IDLE;
                        end else begin
                            tx_data_reg <= rdata_reg[15:8];
                            state_reg   <= TX1;
                        end
                    end
                end
                TX1: begin
                    if (tx_fire) begin
                        tx_data_reg <= rdata_reg[7:0];
                        state_reg   <= TX2;
                    end
                end
                TX2: begin
                    if (tx_fire) begin
                        tx_valid_reg <= 1'b0;
                        state_reg    <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.tx_data  = tx_data_reg;
    assign bus.tx_valid = tx_valid_reg;
    assign trig_level   = trig_level_reg;
    assign deci_rate    = deci_rate_reg;
    assign wave_run     = wave_run_reg;
    assign trig_edge    = trig_edge_reg;
    assign fft_en       = fft_en_reg;
    assign fir_en       = fir_en_reg;
    assign v_scale      = v_scale_reg;
    assign trig_line    = trig_line_reg;
    assign wave_select  = wave_select_reg;
endmodule

// File: tb/tb_dso_reg_ctrl.sv
// Scoreboard bench for dso_reg_ctrl: a register-map model predicts response bytes,
// a monitor pops and compares them on every tx handshake.
module tb_dso_reg_ctrl;
    logic clk = 1'b0;
    logic srst = 1'b1;
    always #5 clk = ~clk;

    dso_reg_ctrl_if bus();

    logic [19:0] ad_freq = 20'h0;
    logic [7:0]  ad_vpp = 8'h0, ad_max = 8'h0, ad_min = 8'h0;
    logic [7:0]  trig_level;
    logic [9:0]  deci_rate;
    logic        wave_run, trig_edge, fft_en, fir_en;
    logic [4:0]  v_scale;
    logic [11:0] trig_line;
    logic [3:0]  wave_select;

    dso_reg_ctrl #(.TIMEOUT_CYC(100)) dut (
        .sys_clk(clk), .sys_rst(srst), .bus(bus),
        .ad_freq(ad_freq), .ad_vpp(ad_vpp), .ad_max(ad_max), .ad_min(ad_min),
        .trig_level(trig_level), .deci_rate(deci_rate), .wave_run(wave_run),
        .trig_edge(trig_edge), .fft_en(fft_en), .fir_en(fir_en), .v_scale(v_scale),
        .trig_line(trig_line), .wave_select(wave_select)
    );

    int compared = 0;
    int mismatched = 0;
    int ready_mode = 0;
    int gap_max = 0;
    logic [7:0] sb[$];

    localparam logic [15:0] MASK [6] = '{16'h00FF, 16'h03FF, 16'h000F, 16'h001F, 16'h0FFF, 16'h000F};
    localparam logic [15:0] RSTV [6] = '{16'h007F, 16'h0001, 16'h0003, 16'h0012, 16'h0200, 16'h0000};
    logic [15:0] m_reg [6];
    logic [3:0]  m_shadow;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_reg[i] = RSTV[i];
        m_shadow = 4'h0;
    endtask

    task automatic check_ctrl(input string tag);
        check({tag, ".trig_level"},  32'(trig_level),  32'(m_reg[0][7:0]));
        check({tag, ".deci_rate"},   32'(deci_rate),   32'(m_reg[1][9:0]));
        check({tag, ".wave_run"},    32'(wave_run),    32'(m_reg[2][0]));
        check({tag, ".trig_edge"},   32'(trig_edge),   32'(m_reg[2][1]));
        check({tag, ".fft_en"},      32'(fft_en),      32'(m_reg[2][2]));
        check({tag, ".fir_en"},      32'(fir_en),      32'(m_reg[2][3]));
        check({tag, ".v_scale"},     32'(v_scale),     32'(m_reg[3][4:0]));
        check({tag, ".trig_line"},   32'(trig_line),   32'(m_reg[4][11:0]));
        check({tag, ".wave_select"}, 32'(wave_select), 32'(m_reg[5][3:0]));
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic send_byte(input logic [7:0] b);
        repeat ($urandom_range(0, gap_max)) begin
            @(posedge clk); #1;
        end
        bus.rx_data = b;
        bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 || bus.tx_valid) begin
            @(posedge clk); #1;
            n++;
            if (n > 3000) begin
                compared++;
                mismatched++;
                $display("FAIL wait_idle: response still pending after %0d cycles, %0d bytes outstanding", n, sb.size());
                sb.delete();
                break;
            end
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [15:0] d);
        send_byte(8'h57); send_byte(a); send_byte(d[15:8]); send_byte(d[7:0]);
        if (a < 8'h06) begin
            m_reg[a[2:0]] = d & MASK[a[2:0]];
            sb.push_back(8'h06);
        end else begin
            sb.push_back(8'h15);
        end
    endtask

    task automatic do_read(input logic [7:0] a, input bit scramble);
        logic [15:0] v;
        send_byte(8'h52); send_byte(a);
        if (a < 8'h06) v = m_reg[a[2:0]];
        else begin
            case (a)
                8'h10: begin v = ad_freq[15:0]; m_shadow = ad_freq[19:16]; end
                8'h11: v = {12'h000, m_shadow};
                8'h12: v = {8'h00, ad_vpp};
                8'h13: v = {8'h00, ad_max};
                8'h14: v = {8'h00, ad_min};
                default: v = 16'h0000;
            endcase
        end
        sb.push_back(a); sb.push_back(v[15:8]); sb.push_back(v[7:0]);
        if (scramble) begin
            @(posedge clk); #1;
            ad_freq = 20'($urandom); ad_vpp = 8'($urandom);
            ad_max = 8'($urandom); ad_min = 8'($urandom);
        end
    endtask

    // tx_ready generator.
    initial begin
        int cnt = 0;
        bus.tx_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: bus.tx_ready = 1'b1;
                1: bus.tx_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (!bus.tx_valid) begin cnt = 0; bus.tx_ready = 1'b0; end
                    else if (cnt < 5) begin cnt++; bus.tx_ready = 1'b0; end
                    else begin cnt = 0; bus.tx_ready = 1'b1; end
                end
            endcase
        end
    end

    // Monitor: compares each accepted byte with the scoreboard and checks stall stability.
    initial begin
        logic       stall = 1'b0;
        logic [7:0] stall_data = 8'h00;
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (srst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    compared++;
                    if (!(bus.tx_valid && bus.tx_data == stall_data)) begin
                        mismatched++;
                        $display("FAIL tx_hold: valid=%0b data=%02h expected held %02h", bus.tx_valid, bus.tx_data, stall_data);
                    end
                end
                if (bus.tx_valid && bus.tx_ready) begin
                    compared++;
                    if (sb.size() == 0) begin
                        mismatched++;
                        $display("FAIL tx_unexpected: got byte %02h expected none", bus.tx_data);
                    end else begin
                        exp = sb.pop_front();
                        if (bus.tx_data !== exp) begin
                            mismatched++;
                            $display("FAIL tx_byte: got %02h expected %02h", bus.tx_data, exp);
                        end else begin
                            $display("tx byte %02h ok", bus.tx_data);
                        end
                    end
                end
                stall = bus.tx_valid && !bus.tx_ready;
                stall_data = bus.tx_data;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a;
        logic [7:0] rd_addrs [11];
        bus.rx_data = 8'h00;
        bus.rx_valid = 1'b0;
        for (int i = 0; i < 6; i++) rd_addrs[i] = 8'(i);
        for (int i = 0; i < 5; i++) rd_addrs[6 + i] = 8'(8'h10 + i);
        model_reset();
        repeat (4) @(posedge clk);
        #1 srst = 1'b0;
        check("reset.tx_valid", 32'(bus.tx_valid), 32'h0);
        check("reset.tx_data", 32'(bus.tx_data), 32'h0);
        check_ctrl("reset");

        ready_mode = 0;
        for (int i = 0; i < 6; i++) begin
            do_read(8'(i), 1'b0);
            wait_idle();
        end

        do_write(8'h01, 16'hFFFF);
        check("deci_rate.exec_cycle", 32'(deci_rate), 32'h001);
        @(posedge clk); #1;
        check("deci_rate.n_plus_2", 32'(deci_rate), 32'h3FF);
        wait_idle();
        do_read(8'h01, 1'b0);
        wait_idle();

        do_write(8'h12, 16'hABCD); wait_idle();
        do_write(8'h3F, 16'h1234); wait_idle();
        check_ctrl("after_nak");

        ad_freq = 20'hABCDE;
        do_read(8'h10, 1'b0); wait_idle();
        ad_freq = 20'h12345;
        do_read(8'h11, 1'b0); wait_idle();

        ready_mode = 2;
        ad_max = 8'h9C;
        do_read(8'h13, 1'b0); wait_idle();
        ready_mode = 0;

        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
        repeat (100) @(posedge clk);
        #1;
        check_ctrl("after_timeout");
        do_read(8'h00, 1'b0); wait_idle();

        // Gaps shorter than the timeout must not break a frame.
        send_byte(8'h57); repeat (90) @(posedge clk); #1;
        send_byte(8'h05); repeat (90) @(posedge clk); #1;
        send_byte(8'h00); repeat (90) @(posedge clk); #1;
        send_byte(8'h09);
        m_reg[5] = 16'h0009;
        sb.push_back(8'h06);
        wait_idle();
        check_ctrl("slow_write");

        ready_mode = 1;
        gap_max = 3;
        for (int it = 0; it < 80; it++) begin
            int op = $urandom_range(0, 9);
            if (op == 0) begin
                a = 8'($urandom);
                if (a == 8'h57 || a == 8'h52) a = 8'hA5;
                send_byte(a);
            end else if (op < 5) begin
                a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
                do_write(a, 16'($urandom));
                wait_idle();
                check_ctrl("rand_write");
            end else begin
                a = ($urandom_range(0, 4) == 0) ? 8'($urandom) : rd_addrs[$urandom_range(0, 10)];
                do_read(a, 1'b1);
                wait_idle();
            end
        end
        gap_max = 0;

        // Reset in the middle of a stalled response.
        ready_mode = 2;
        do_write(8'h03, 16'h0007); 
        begin
            int n = 0;
            while (!bus.tx_valid && n < 20) begin @(posedge clk); #1; n++; end
        end
        srst = 1'b1;
        sb.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1 srst = 1'b0;
        check("midreset.tx_valid", 32'(bus.tx_valid), 32'h0);
        check("midreset.tx_data", 32'(bus.tx_data), 32'h0);
        check_ctrl("midreset");
        ready_mode = 0;
        do_read(8'h11, 1'b0); wait_idle();
        do_read(8'h03, 1'b0); wait_idle();

        repeat (5) @(posedge clk);
        check("final.queue_empty", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
